// File: rtl/wbm_single.sv
// wbm_single: Wishbone B4 pipelined single-cycle bus initiator with a strobe/busy command port.
// Optional cycle timeout is compiled in with `define WBM_SINGLE_TIMEOUT_EN.
module wbm_single #(
  parameter int AW             = 30,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TW             = 10
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_stb,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [31:0]   i_cmd_data,
  input  logic [3:0]    i_cmd_sel,
  output logic          o_cmd_busy,
  output logic          o_rsp_stb,
  output logic [31:0]   o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);
  if (2**TW <= TIMEOUT_CYCLES) begin : g_tw_check
    $error("TW too narrow for TIMEOUT_CYCLES");
  end
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    sel_q, sel_d;
  logic          rsp_stb_q, rsp_stb_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          accept, taken, bus_done, tmo, tmo_hit, fin, fin_err;
`ifdef WBM_SINGLE_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  assign tmo = cnt_q == TW'(TIMEOUT_CYCLES);
  always_comb cnt_d = accept ? '0 : (state_q != S_IDLE) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif
  // A response in the same cycle the request is taken completes it directly.
  always_comb begin
    accept   = (state_q == S_IDLE) && i_cmd_stb;
    taken    = (state_q == S_WAIT) || ((state_q == S_REQ) && !i_wb_stall);
    bus_done = taken && (i_wb_ack || i_wb_err);
    tmo_hit  = (state_q != S_IDLE) && tmo && !bus_done;
    fin      = bus_done || tmo_hit;
    fin_err  = (taken && i_wb_err) || tmo_hit;
    state_d  = accept ? S_REQ :
               fin ? S_IDLE :
               (state_q == S_REQ && !i_wb_stall) ? S_WAIT : state_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    we_d       = accept ? i_cmd_we : we_q;
    addr_d     = accept ? i_cmd_addr : addr_q;
    data_d     = accept ? i_cmd_data : data_q;
    sel_d      = accept ? i_cmd_sel : sel_q;
    rsp_stb_d  = fin;
    rsp_err_d  = fin_err;
    rsp_data_d = fin_err ? '0 : (fin && !we_q) ? i_wb_data : rsp_data_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  always_comb begin
    o_wb_cyc   = state_q != S_IDLE;
    o_wb_stb   = state_q == S_REQ;
    o_cmd_busy = state_q != S_IDLE;
    o_wb_we    = we_q;
    o_wb_addr  = addr_q;
    o_wb_data  = data_q;
    o_wb_sel   = sel_q;
    o_rsp_stb  = rsp_stb_q;
    o_rsp_err  = rsp_err_q;
    o_rsp_data = rsp_data_q;
  end
endmodule

// File: tb/tb_wbm_single.sv
// tb_wbm_single: table-driven vectors plus hand sequences for timeout and async reset of wbm_single.
module tb_wbm_single;
  localparam int AW = 30;
  localparam int OW = 6 + AW + 32 + 4 + 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n;
  logic          cmd_stb, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic [3:0]    cmd_sel;
  logic          cmd_busy, rsp_stb, rsp_err;
  logic [31:0]   rsp_data;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [3:0]    wb_sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [31:0]   wb_rdata;
  int checks = 0;
  int failures = 0;
  wbm_single #(.AW(AW), .TIMEOUT_CYCLES(8), .TW(10)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_stb(cmd_stb), .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr),
    .i_cmd_data(cmd_data), .i_cmd_sel(cmd_sel),
    .o_cmd_busy(cmd_busy), .o_rsp_stb(rsp_stb), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );
  typedef struct {
    logic          stb, we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    sel;
    logic          stall, ack, err;
    logic [31:0]   rdata;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t v[$];
  function automatic void add(input logic stb, we, input logic [AW-1:0] addr,
                              input logic [31:0] data, input logic [3:0] sel,
                              input logic stall, ack, err, input logic [31:0] rdata,
                              input logic cyc, wstb, busy, rsp, rerr, ewe,
                              input logic [AW-1:0] eaddr, input logic [31:0] ewd,
                              input logic [3:0] esel, input logic [31:0] erd);
    vec_t t;
    t.stb = stb; t.we = we; t.addr = addr; t.data = data; t.sel = sel;
    t.stall = stall; t.ack = ack; t.err = err; t.rdata = rdata;
    t.exp = {cyc, wstb, busy, rsp, rerr, ewe, eaddr, ewd, esel, erd};
    v.push_back(t);
  endfunction
  function automatic logic [OW-1:0] obs();
    return {wb_cyc, wb_stb, cmd_busy, rsp_stb, rsp_err, wb_we, wb_addr, wb_wdata, wb_sel, rsp_data};
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input vec_t t);
    cmd_stb = t.stb; cmd_we = t.we; cmd_addr = t.addr; cmd_data = t.data; cmd_sel = t.sel;
    wb_stall = t.stall; wb_ack = t.ack; wb_err = t.err; wb_rdata = t.rdata;
  endtask
  task automatic idle_in();
    cmd_stb = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_rdata = '0;
  endtask
  initial begin
    int k, hi, nrsp;
    // idle, stray ack ignored
    add(0,0,0,0,0,       0,1,0,32'h1,         0,0,0,0,0,0, 0,0,0,0);
    // zero-wait write
    add(1,1,0,32'h00010001,4'hF, 0,0,0,0,     1,1,1,0,0,1, 0,32'h00010001,4'hF,0);
    add(0,0,0,0,0,       0,0,0,0,             1,0,1,0,0,1, 0,32'h00010001,4'hF,0);
    add(0,0,0,0,0,       0,1,0,32'hDEADBEEF,  0,0,0,1,0,1, 0,32'h00010001,4'hF,0);
    add(0,0,0,0,0,       0,0,0,0,             0,0,0,0,0,1, 0,32'h00010001,4'hF,0);
    // read with 4 stall cycles
    add(1,0,3,32'h12345678,4'h3, 1,0,0,0,     1,1,1,0,0,0, 3,32'h12345678,4'h3,0);
    for (int i = 0; i < 4; i++)
      add(0,0,0,0,0,     1,0,0,0,             1,1,1,0,0,0, 3,32'h12345678,4'h3,0);
    add(0,0,0,0,0,       0,0,0,0,             1,0,1,0,0,0, 3,32'h12345678,4'h3,0);
    add(0,0,0,0,0,       0,1,0,32'hA5A50003,  0,0,0,1,0,0, 3,32'h12345678,4'h3,32'hA5A50003);
    // bus error in WAIT
    add(1,0,7,0,4'hF,    0,0,0,0,             1,1,1,0,0,0, 7,0,4'hF,32'hA5A50003);
    add(0,0,0,0,0,       0,0,0,0,             1,0,1,0,0,0, 7,0,4'hF,32'hA5A50003);
    add(0,0,0,0,0,       0,0,1,32'h11112222,  0,0,0,1,1,0, 7,0,4'hF,0);
    add(0,0,0,0,0,       0,0,0,0,             0,0,0,0,0,0, 7,0,4'hF,0);
    // ack in the same cycle the request is taken
    add(1,0,8,0,4'hF,    0,0,0,0,             1,1,1,0,0,0, 8,0,4'hF,0);
    add(0,0,0,0,0,       0,1,0,32'h0BADF00D,  0,0,0,1,0,0, 8,0,4'hF,32'h0BADF00D);
    // new command in the rsp_stb cycle, then busy commands ignored
    add(1,0,9,32'h99,4'h2, 0,0,0,0,           1,1,1,0,0,0, 9,32'h99,4'h2,32'h0BADF00D);
    add(1,1,5,32'h55,4'h5, 1,0,0,0,           1,1,1,0,0,0, 9,32'h99,4'h2,32'h0BADF00D);
    add(1,1,5,32'h55,4'h5, 0,1,1,32'hFFFFFFFF, 0,0,0,1,1,0, 9,32'h99,4'h2,0);
    add(1,1,12,32'hCAFE0000,4'h1, 0,0,0,0,    1,1,1,0,0,1, 12,32'hCAFE0000,4'h1,0);
    add(0,0,0,0,0,       0,0,0,0,             1,0,1,0,0,1, 12,32'hCAFE0000,4'h1,0);
    add(0,0,0,0,0,       0,1,1,32'h12345678,  0,0,0,1,1,1, 12,32'hCAFE0000,4'h1,0);
    add(0,0,0,0,0,       0,1,1,0,             0,0,0,0,0,1, 12,32'hCAFE0000,4'h1,0);
    rst_n = 0;
    idle_in();
    tick();
    tick();
    chk("reset_state", obs(), '0);
    rst_n = 1;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      tick();
      chk($sformatf("vec[%0d]", i), obs(), v[i].exp);
    end
    idle_in();
    cmd_stb = 1; cmd_addr = 'h20; cmd_sel = 4'hF;
    tick();
    idle_in();
    chk("to_stb", {wb_cyc, wb_stb}, 2'b11);
`ifdef WBM_SINGLE_TIMEOUT_EN
    k = 0;
    do begin
      tick();
      k++;
    end while (!rsp_stb && k < 50);
    chk("to_latency", k, 9);
    chk("to_rsp", {rsp_err, rsp_data, wb_cyc}, {1'b1, 32'h0, 1'b0});
`else
    hi = 0;
    repeat (120) begin
      tick();
      if (wb_cyc && !rsp_stb) hi++;
    end
    chk("no_timeout_cyc", hi, 120);
`endif
    if (!cmd_busy) begin
      cmd_stb = 1; cmd_we = 0; cmd_addr = 'h21; cmd_sel = 4'hF;
      tick();
      idle_in();
      tick();
    end
    chk("rst_pre_wait", {wb_cyc, wb_stb, cmd_busy}, 3'b101);
    #2 rst_n = 0;
    #1;
    chk("rst_async", {wb_cyc, wb_stb, cmd_busy}, 3'b000);
    tick();
    tick();
    rst_n = 1;
    wb_ack = 1;
    wb_rdata = 32'h77777777;
    nrsp = 0;
    repeat (5) begin
      tick();
      if (rsp_stb) nrsp++;
    end
    chk("rst_no_rsp", {nrsp, rsp_data, wb_cyc}, {32'd0, 32'h0, 1'b0});
    idle_in();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
